i2c_slave: RTL

Single-byte I2C target that answers the team's I2C master on the same SCL/SDA pair, on the downstream side of the bus. It oversamples SCL/SDA on the system clock, detects START/STOP, matches a 7-bit own address and ACKs. On a write it delivers the received byte to the user side; on a read it fetches a byte from the user side and shifts it out. SDA is open-drain: the block only ever drives 0 or Z.

---
 rtl/i2c_slave.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave.sv
// Single-byte I2C target: oversampled SCL/SDA, 7-bit address match with ACK,
// one write byte to the user side or one read byte from it. SDA is open-drain.
module i2c_slave #(
  parameter int         SYS_FREQ    = 40000000,
  parameter int         I2C_FREQ    = 100000,
  parameter logic [6:0] OWN_ADDR    = 7'h78,
  parameter int         RELEASE_CYC = (SYS_FREQ / I2C_FREQ) * 3 / 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] wr_data,
  output logic       wr_valid,
  input  logic [7:0] rd_data,
  output logic       rd_req,
  output logic       rd_done,
  output logic       rd_nack,
  output logic       busy
);

  localparam int CNT_W = $clog2(RELEASE_CYC + 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_t;

  state_t     state, state_n;
  logic [1:0] scl_s, sda_s;
  logic       scl_d, sda_d, sample_evt, drive_evt;
  logic       start_det, stop_det;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic [7:0] shift, shift_n;
  logic       sda_oe, sda_oe_n;
  logic       phase, phase_n;
  logic       rw, rw_n;
  logic [CNT_W-1:0] high_cnt, high_cnt_n;
  logic [7:0] wr_data_n;
  logic       wr_valid_n, rd_req_n, rd_done_n, rd_nack_n, busy_n;

  // Synchronisers idle high so a reset does not fabricate bus edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_s      <= 2'b11;
      sda_s      <= 2'b11;
      scl_d      <= 1'b1;
      sda_d      <= 1'b1;
      sample_evt <= 1'b0;
      drive_evt  <= 1'b0;
    end else begin
      scl_s      <= {scl_s[0], scl};
      sda_s      <= {sda_s[0], sda};
      scl_d      <= scl_s[1];
      sda_d      <= sda_s[1];
      sample_evt <= scl_s[1] & ~scl_d;
      drive_evt  <= ~scl_s[1] & scl_d;
    end
  end

  assign start_det = scl_s[1] & scl_d & sda_d & ~sda_s[1] & ~sda_oe;
  assign stop_det  = scl_s[1] & scl_d & ~sda_d & sda_s[1] & ~sda_oe;
  assign sda       = sda_oe ? 1'b0 : 1'bz;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shift    <= '0;
      sda_oe   <= 1'b0;
      phase    <= 1'b0;
      rw       <= 1'b0;
      high_cnt <= '0;
      wr_data  <= '0;
      wr_valid <= 1'b0;
      rd_req   <= 1'b0;
      rd_done  <= 1'b0;
      rd_nack  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      shift    <= shift_n;
      sda_oe   <= sda_oe_n;
      phase    <= phase_n;
      rw       <= rw_n;
      high_cnt <= high_cnt_n;
      wr_data  <= wr_data_n;
      wr_valid <= wr_valid_n;
      rd_req   <= rd_req_n;
      rd_done  <= rd_done_n;
      rd_nack  <= rd_nack_n;
      busy     <= busy_n;
    end
  end

  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift;
    sda_oe_n   = sda_oe;
    phase_n    = phase;
    rw_n       = rw;
    high_cnt_n = high_cnt;
    wr_data_n  = wr_data;
    wr_valid_n = 1'b0;
    rd_req_n   = 1'b0;
    rd_done_n  = 1'b0;
    rd_nack_n  = rd_nack;
    busy_n     = busy;

    if (stop_det) begin
      state_n   = IDLE;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b0;
    end else if (start_det) begin
      state_n   = ADDR;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b0;
    end else begin
      case (state)
        IDLE: ;
        ADDR: if (sample_evt) begin
          shift_n   = {shift[6:0], sda_s[1]};
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            bit_cnt_n = '0;
            if (shift[6:0] == OWN_ADDR) begin
              busy_n   = 1'b1;
              rw_n     = sda_s[1];
              rd_req_n = sda_s[1];
              phase_n  = 1'b0;
              state_n  = ADDR_ACK;
            end else begin
              state_n = WAIT_STOP;
            end
          end
        end
        // phase 0: first fall starts the ACK; phase 1: next fall ends it.
        ADDR_ACK: if (drive_evt) begin
          if (!phase) begin
            sda_oe_n = 1'b1;
            phase_n  = 1'b1;
          end else begin
            bit_cnt_n = '0;
            if (rw) begin
              shift_n  = rd_data;
              sda_oe_n = ~rd_data[7];
              state_n  = RD_DATA;
            end else begin
              sda_oe_n = 1'b0;
              state_n  = WR_DATA;
            end
          end
        end
        WR_DATA: if (sample_evt) begin
          shift_n   = {shift[6:0], sda_s[1]};
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            bit_cnt_n  = '0;
            wr_data_n  = {shift[6:0], sda_s[1]};
            wr_valid_n = 1'b1;
            phase_n    = 1'b0;
            state_n    = WR_ACK;
          end
        end
        // The master goes straight into STOP without an SCL fall, so the
        // ACK is also dropped after a long SCL-high stretch.
        WR_ACK: begin
          if (!phase) begin
            if (drive_evt) begin
              sda_oe_n   = 1'b1;
              phase_n    = 1'b1;
              high_cnt_n = '0;
            end
          end else if (drive_evt ||
                       (scl_s[1] && high_cnt == CNT_W'(RELEASE_CYC - 1))) begin
            sda_oe_n = 1'b0;
            state_n  = WAIT_STOP;
          end else if (scl_s[1]) begin
            high_cnt_n = high_cnt + 1'b1;
          end else begin
            high_cnt_n = '0;
          end
        end
        RD_DATA: if (drive_evt) begin
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            bit_cnt_n = '0;
            sda_oe_n  = 1'b0;
            state_n   = RD_ACK;
          end else begin
            shift_n  = {shift[6:0], 1'b0};
            sda_oe_n = ~shift[6];
          end
        end
        RD_ACK: if (sample_evt) begin
          rd_nack_n = sda_s[1];
          rd_done_n = 1'b1;
          state_n   = WAIT_STOP;
        end
        WAIT_STOP: sda_oe_n = 1'b0;
        default: state_n = IDLE;
      endcase
    end
  end

endmodule
